// File: rtl/sseg_pkg.sv
// Shared types for the multiplexed 7-segment driver.
// Segment patterns are {dp,g..a}, active-low.
package sseg_pkg;

    typedef logic [7:0] sseg_t;

    localparam sseg_t SSEG_BLANK = 8'hFF;

endpackage

// File: rtl/disp_timebase.sv
// Scan timebase: free-running slot counter, digit index, and a strobe
// that is high on the cycle whose closing edge returns the scan to digit 0.
module disp_timebase #(
    parameter int N_DIGITS  = 8,
    parameter int SLOT_BITS = 14
) (
    input  logic                        clk,
    input  logic                        reset_n,
    output logic [SLOT_BITS-1:0]        slot_cnt_o,
    output logic [$clog2(N_DIGITS)-1:0] digit_o,
    output logic                        frame_wrap_o
);

    localparam int DIG_W = $clog2(N_DIGITS);

    logic [SLOT_BITS-1:0] slot_cnt_q, slot_cnt_d;
    logic [DIG_W-1:0]     digit_q, digit_d;
    logic                 slot_last, dig_last;

    assign slot_last = &slot_cnt_q;
    assign dig_last  = (digit_q == DIG_W'(N_DIGITS - 1));

    always_comb begin
        slot_cnt_d = slot_cnt_q + SLOT_BITS'(1);
        digit_d    = digit_q;
        if (slot_last) begin
            digit_d = dig_last ? '0 : digit_q + DIG_W'(1);
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            slot_cnt_q <= '0;
            digit_q    <= '0;
        end else begin
            slot_cnt_q <= slot_cnt_d;
            digit_q    <= digit_d;
        end
    end

    assign slot_cnt_o   = slot_cnt_q;
    assign digit_o      = digit_q;
    assign frame_wrap_o = slot_last && dig_last;

endmodule

// File: rtl/sseg_mux_pwm.sv
// N-digit common-anode display scanner with PWM brightness, per-digit
// blanking and a double-buffered configuration committed at frame boundaries.
module sseg_mux_pwm
    import sseg_pkg::*;
#(
    parameter int N_DIGITS  = 8,
    parameter int SLOT_BITS = 14,
    parameter int PWM_BITS  = 4
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic [8*N_DIGITS-1:0] in,
    input  logic [N_DIGITS-1:0]   en_mask,
    input  logic [PWM_BITS-1:0]   bright,
    input  logic                  load,
    output logic [N_DIGITS-1:0]   an,
    output logic [7:0]            sseg,
    output logic                  frame_tick
);

    localparam int DIG_W = $clog2(N_DIGITS);

    typedef struct packed {
        sseg_t [N_DIGITS-1:0] data;
        logic  [N_DIGITS-1:0] en_mask;
        logic  [PWM_BITS-1:0] bright;
    } disp_cfg_t;

    localparam disp_cfg_t CFG_RST = '{
        data:    {N_DIGITS{SSEG_BLANK}},
        en_mask: '0,
        bright:  '0
    };

    logic [SLOT_BITS-1:0] slot_cnt;
    logic [DIG_W-1:0]     digit;
    logic                 frame_wrap;

    disp_timebase #(
        .N_DIGITS  (N_DIGITS),
        .SLOT_BITS (SLOT_BITS)
    ) u_timebase (
        .clk          (clk),
        .reset_n      (reset_n),
        .slot_cnt_o   (slot_cnt),
        .digit_o      (digit),
        .frame_wrap_o (frame_wrap)
    );

    disp_cfg_t live_cfg;
    disp_cfg_t act_q, act_d;
    disp_cfg_t pend_q, pend_d;
    logic      pend_vld_q, pend_vld_d;

    assign live_cfg = '{data: in, en_mask: en_mask, bright: bright};

    // A load on the boundary edge bypasses pending so it lands in this frame.
    always_comb begin
        act_d      = act_q;
        pend_d     = pend_q;
        pend_vld_d = pend_vld_q;
        if (load) begin
            pend_d     = live_cfg;
            pend_vld_d = 1'b1;
        end
        if (frame_wrap) begin
            if (load) begin
                act_d      = live_cfg;
                pend_vld_d = 1'b0;
            end else if (pend_vld_q) begin
                act_d      = pend_q;
                pend_vld_d = 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            act_q      <= CFG_RST;
            pend_q     <= CFG_RST;
            pend_vld_q <= 1'b0;
        end else begin
            act_q      <= act_d;
            pend_q     <= pend_d;
            pend_vld_q <= pend_vld_d;
        end
    end

    logic [PWM_BITS-1:0] phase;
    logic                lit;
    logic [N_DIGITS-1:0] an_q, an_d;
    sseg_t               sseg_q, sseg_d;
    logic                tick_q, tick_d;

    assign phase = slot_cnt[SLOT_BITS-1 -: PWM_BITS];
    assign lit   = act_q.en_mask[digit] && (phase <= act_q.bright);

    always_comb begin
        an_d   = '1;
        sseg_d = SSEG_BLANK;
        tick_d = (slot_cnt == '0) && (digit == '0);
        if (lit) begin
            an_d   = ~(N_DIGITS'(1) << digit);
            sseg_d = act_q.data[digit];
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            an_q   <= '1;
            sseg_q <= SSEG_BLANK;
            tick_q <= 1'b0;
        end else begin
            an_q   <= an_d;
            sseg_q <= sseg_d;
            tick_q <= tick_d;
        end
    end

    assign an         = an_q;
    assign sseg       = sseg_q;
    assign frame_tick = tick_q;

endmodule

// File: tb/tb_sseg_mux_pwm.sv
// Scoreboard bench for sseg_mux_pwm: 4 digits, 16-cycle slots, 64-cycle frames.
module tb_sseg_mux_pwm;

    localparam int ND = 4;
    localparam int SB = 4;
    localparam int PB = 2;

    logic        clk = 1'b0;
    logic        reset_n;
    logic [31:0] din;
    logic [3:0]  mask;
    logic [1:0]  bright;
    logic        load;
    logic [3:0]  an;
    logic [7:0]  sseg;
    logic        ft;

    sseg_mux_pwm #(
        .N_DIGITS  (ND),
        .SLOT_BITS (SB),
        .PWM_BITS  (PB)
    ) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .in         (din),
        .en_mask    (mask),
        .bright     (bright),
        .load       (load),
        .an         (an),
        .sseg       (sseg),
        .frame_tick (ft)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int         cyc;
        logic [3:0] an;
        logic [7:0] sseg;
        logic       ft;
        int         tid;
    } exp_t;

    exp_t q[$];
    int   n_vec = 0;
    int   n_err = 0;

    task automatic push1(input int c, input logic [3:0] a, input logic [7:0] s,
                         input logic f, input int tid);
        exp_t e;
        e.cyc = c; e.an = a; e.sseg = s; e.ft = f; e.tid = tid;
        q.push_back(e);
    endtask

    // Expected outputs for one frame whose first output cycle is 'start'.
    task automatic push_frame(input int start, input int nent, input logic [31:0] d,
                              input logic [3:0] m, input logic [1:0] b, input int tid);
        logic [3:0] one;
        one = 4'b0001;
        for (int j = 0; j < nent; j++) begin
            int  dg, p;
            logic lt;
            dg = j / 16;
            p  = j % 16;
            lt = m[dg] && ((p / 4) <= int'(b));
            if (lt) push1(start + j, ~(one << dg), d[dg*8 +: 8], j == 0, tid);
            else    push1(start + j, 4'hF, 8'hFF, j == 0, tid);
        end
    endtask

    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            while (q.size() > 0 && q[0].cyc <= cyc) begin
                e = q.pop_front();
                n_vec++;
                if (e.cyc < cyc) begin
                    n_err++;
                    $display("FAIL test%0d missed cyc %0d (now %0d)", e.tid, e.cyc, cyc);
                end else if (an !== e.an || sseg !== e.sseg || ft !== e.ft) begin
                    n_err++;
                    $display("FAIL test%0d cyc %0d: got an=%b sseg=%h tick=%b, want an=%b sseg=%h tick=%b",
                             e.tid, cyc, an, sseg, ft, e.an, e.sseg, e.ft);
                end
            end
        end
    end

    task automatic wait_cyc(input int n);
        while (cyc < n) @(negedge clk);
    endtask

    // Drive a load pulse captured by edge n; live inputs are scrambled afterwards.
    task automatic load_at(input int n, input logic [31:0] d, input logic [3:0] m,
                           input logic [1:0] b);
        wait_cyc(n - 1);
        din = d; mask = m; bright = b; load = 1'b1;
        @(negedge clk);
        load = 1'b0; din = 32'hDEADBEEF; mask = 4'hA; bright = 2'd0;
    endtask

    localparam logic [31:0] DA  = 32'h04030201;
    localparam logic [31:0] DC  = 32'h88C0F9A4;
    localparam logic [31:0] DE  = 32'h11223344;
    localparam logic [31:0] DD  = 32'h92B0A4F9;
    localparam logic [31:0] DF1 = 32'h55555555;
    localparam logic [31:0] DF2 = 32'h7F7E7D7C;

    int r, x, r2;

    initial begin
        reset_n = 1'b0; load = 1'b0; din = '0; mask = '0; bright = '0;
        for (int c = 1; c <= 4; c++) push1(c, 4'hF, 8'hFF, 1'b0, 1);
        wait_cyc(4);
        reset_n = 1'b1;
        r = 4;

        push_frame(r + 1,  64, 32'h0, 4'h0, 2'd0, 1);
        push_frame(r + 65, 64, 32'h0, 4'h0, 2'd0, 1);

        load_at(r + 84, DA, 4'hF, 2'd3);
        push_frame(r + 129, 64, DA, 4'hF, 2'd3, 2);

        load_at(r + 138, DA, 4'hF, 2'd1);
        push_frame(r + 193, 64, DA, 4'hF, 2'd1, 3);

        load_at(r + 222, DC, 4'hF, 2'd3);
        push_frame(r + 257, 64, DC, 4'hF, 2'd3, 4);

        load_at(r + 296, DE, 4'hF, 2'd2);
        load_at(r + 320, DD, 4'hF, 2'd0);
        push_frame(r + 321, 64, DD, 4'hF, 2'd0, 4);

        load_at(r + 325, DF1, 4'hF, 2'd3);
        load_at(r + 340, DF2, 4'b0101, 2'd2);
        push_frame(r + 385, 64, DF2, 4'b0101, 2'd2, 5);

        x = r + 449 + 39;
        push_frame(r + 449, 39, DF2, 4'b0101, 2'd2, 6);
        for (int c = x; c <= x + 3; c++) push1(c, 4'hF, 8'hFF, 1'b0, 6);
        wait_cyc(x - 1);
        @(posedge clk);
        #2 reset_n = 1'b0;
        wait_cyc(x + 3);
        reset_n = 1'b1;
        r2 = x + 3;
        push_frame(r2 + 1, 64, 32'h0, 4'h0, 2'd0, 6);
        load_at(r2 + 20, DA, 4'hF, 2'd3);
        push_frame(r2 + 65, 64, DA, 4'hF, 2'd3, 6);

        for (int i = 0; i < 300 && q.size() > 0; i++) @(negedge clk);
        if (q.size() > 0) begin
            n_err++;
            $display("FAIL drain timeout: %0d entries left, want 0", q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
